// File: rtl/draw_port_arbiter.sv
// Round-robin arbiter sharing one VGA pixel write port between NUM_REQ drawing engines.
// A grant lasts for a whole burst; winner pixels are registered onto vga_*.
module draw_port_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COL_W     = 3,
  parameter int MAX_BURST = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       wr,
  input  logic [NUM_REQ*X_W-1:0]   x_in,
  input  logic [NUM_REQ*Y_W-1:0]   y_in,
  input  logic [NUM_REQ*COL_W-1:0] col_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [COL_W-1:0]         vga_colour,
  output logic                     vga_plot,
  output logic                     busy
);
  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t                          state, state_d;
  logic [LW-1:0]                   last, last_d, win;
  logic                            win_vld;
  logic [CW-1:0]                   cnt, cnt_d;
  logic [CW:0]                     cnt_inc;
  logic [NUM_REQ-1:0]              gnt_d, done_d, own_oh;
  logic                            plot_d, busy_d;
  logic [X_W-1:0]                  x_d;
  logic [Y_W-1:0]                  y_d;
  logic [COL_W-1:0]                c_d;
  logic                            wr_g, req_g, others, cap_hit;
  logic [NUM_REQ-1:0][X_W-1:0]     xs;
  logic [NUM_REQ-1:0][Y_W-1:0]     ys;
  logic [NUM_REQ-1:0][COL_W-1:0]   cs;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign xs[i] = x_in[i*X_W +: X_W];
    assign ys[i] = y_in[i*Y_W +: Y_W];
    assign cs[i] = col_in[i*COL_W +: COL_W];
  end

  assign own_oh  = NUM_REQ'(1) << last;
  assign wr_g    = wr[last];
  assign req_g   = req[last];
  assign others  = |(req & ~own_oh);
  assign cnt_inc = {1'b0, cnt} + {{CW{1'b0}}, wr_g};
  // Cap counts the write happening this cycle, so the capped pixel is still plotted.
  assign cap_hit = (MAX_BURST != 0) && (cnt_inc >= (CW+1)'(MAX_BURST));

  // Scan last+1, last+2, ... wrapping, so the previous owner has lowest priority.
  always_comb begin
    logic [LW:0] sum;
    win     = last;
    win_vld = 1'b0;
    sum     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum = {1'b0, last} + (LW+1)'(i);
      if (sum >= (LW+1)'(NUM_REQ)) sum = sum - (LW+1)'(NUM_REQ);
      if (!win_vld && req[sum[LW-1:0]]) begin
        win_vld = 1'b1;
        win     = sum[LW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    done_d  = '0;
    last_d  = last;
    cnt_d   = cnt;
    plot_d  = 1'b0;
    x_d     = vga_x;
    y_d     = vga_y;
    c_d     = vga_colour;
    case (state)
      S_IDLE: begin
        if (win_vld) begin
          gnt_d   = NUM_REQ'(1) << win;
          last_d  = win;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (wr_g) begin
          plot_d = 1'b1;
          x_d    = xs[last];
          y_d    = ys[last];
          c_d    = cs[last];
          if (MAX_BURST != 0) cnt_d = cap_hit ? CW'(MAX_BURST) : cnt_inc[CW-1:0];
        end
        if (!req_g || (cap_hit && others)) begin
          gnt_d   = '0;
          done_d  = own_oh;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      last       <= LW'(NUM_REQ - 1);
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      last       <= last_d;
      cnt        <= cnt_d;
      gnt        <= gnt_d;
      done       <= done_d;
      vga_plot   <= plot_d;
      vga_x      <= x_d;
      vga_y      <= y_d;
      vga_colour <= c_d;
      busy       <= busy_d;
    end
  end
endmodule

// File: tb/tb_draw_port_arbiter.sv
// Bench for draw_port_arbiter (MAX_BURST=4): per-cycle vector tables for grant/done/busy,
// plus a pixel scoreboard filled when an honoured write is driven and drained on vga_plot.
module tb_draw_port_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req = '0, wr = '0;
  logic [23:0] x_in = '0;
  logic [20:0] y_in = '0;
  logic [8:0]  col_in = '0;
  logic [2:0]  gnt, done;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot, busy;

  draw_port_arbiter #(.NUM_REQ(3), .X_W(8), .Y_W(7), .COL_W(3), .MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .wr(wr),
    .x_in(x_in), .y_in(y_in), .col_in(col_in),
    .gnt(gnt), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req, wr;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int         own;
    bit         hon;
    logic [2:0] eg, ed;
    bit         eb;
  } vec_t;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t sb[$];
  pix_t lastp;
  vec_t tab[$];
  int   tests = 0, errors = 0;

  function automatic vec_t V(input logic [2:0] r, input logic [2:0] w, input int x, input int y,
                             input int c, input int own, input bit hon,
                             input logic [2:0] eg, input logic [2:0] ed, input bit eb);
    vec_t v;
    v.req = r; v.wr = w; v.x = 8'(x); v.y = 7'(y); v.c = 3'(c);
    v.own = own; v.hon = hon; v.eg = eg; v.ed = ed; v.eb = eb;
    return v;
  endfunction

  // Each requester sees a distinct pixel derived from the vector's base values.
  function automatic pix_t pix_of(input vec_t v, input int i);
    pix_t p;
    p.x = v.x + 8'(i * 50);
    p.y = v.y + 7'(i);
    p.c = v.c ^ 3'(i);
    return p;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pix_t p;
    req = v.req;
    wr  = v.wr;
    for (int i = 0; i < 3; i++) begin
      p = pix_of(v, i);
      x_in[i*8 +: 8]   = p.x;
      y_in[i*7 +: 7]   = p.y;
      col_in[i*3 +: 3] = p.c;
    end
  endtask

  task automatic check_pix(input string nm);
    pix_t p;
    if (vga_plot) begin
      if (sb.size() == 0) chk({nm, " spurious plot"}, 32'(vga_plot), 0);
      else begin
        p = sb.pop_front();
        chk({nm, " vga_x"}, 32'(vga_x), 32'(p.x));
        chk({nm, " vga_y"}, 32'(vga_y), 32'(p.y));
        chk({nm, " vga_colour"}, 32'(vga_colour), 32'(p.c));
        lastp = p;
      end
    end else begin
      if (sb.size() != 0) begin
        void'(sb.pop_front());
        chk({nm, " missing plot"}, 32'(vga_plot), 1);
      end else chk({nm, " vga_x hold"}, 32'(vga_x), 32'(lastp.x));
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    drive(v);
    if (v.hon) sb.push_back(pix_of(v, v.own));
    @(posedge clk);
    #1;
    chk({nm, " gnt"}, 32'(gnt), 32'(v.eg));
    chk({nm, " done"}, 32'(done), 32'(v.ed));
    chk({nm, " busy"}, 32'(busy), 32'(v.eb));
    check_pix(nm);
  endtask

  task automatic run_tab(input string nm);
    foreach (tab[k]) step(tab[k], $sformatf("%s[%0d]", nm, k));
    tab.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0; wr = '0;
    #1;
    chk("reset gnt", 32'(gnt), 0);
    chk("reset done", 32'(done), 0);
    chk("reset plot", 32'(vga_plot), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset vga_x", 32'(vga_x), 0);
    chk("reset vga_y", 32'(vga_y), 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    lastp = '{x: 8'd0, y: 7'd0, c: 3'd0};
  endtask

  initial begin
    lastp = '{x: 8'd0, y: 7'd0, c: 3'd0};

    // Single requester, four pixels x=10..13
    do_reset();
    tab.push_back(V(3'b001, 3'b000, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1));
    for (int k = 0; k < 4; k++) tab.push_back(V(3'b001, 3'b001, 10 + k, 5, 3, 0, 1, 3'b001, 3'b000, 1));
    tab.push_back(V(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b001, 1));
    tab.push_back(V(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    run_tab("single");

    // Round-robin 0,1,2,0; last write lands on the req-drop cycle
    do_reset();
    tab.push_back(V(3'b111, 3'b000, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1));
    tab.push_back(V(3'b111, 3'b001, 30, 1, 1, 0, 1, 3'b001, 3'b000, 1));
    tab.push_back(V(3'b110, 3'b001, 31, 2, 2, 0, 1, 3'b000, 3'b001, 1));
    tab.push_back(V(3'b111, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    tab.push_back(V(3'b111, 3'b000, 0, 0, 0, 0, 0, 3'b010, 3'b000, 1));
    tab.push_back(V(3'b111, 3'b010, 32, 3, 3, 1, 1, 3'b010, 3'b000, 1));
    tab.push_back(V(3'b101, 3'b010, 33, 4, 4, 1, 1, 3'b000, 3'b010, 1));
    tab.push_back(V(3'b111, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    tab.push_back(V(3'b111, 3'b000, 0, 0, 0, 0, 0, 3'b100, 3'b000, 1));
    tab.push_back(V(3'b111, 3'b100, 34, 5, 5, 2, 1, 3'b100, 3'b000, 1));
    tab.push_back(V(3'b011, 3'b100, 35, 6, 6, 2, 1, 3'b000, 3'b100, 1));
    tab.push_back(V(3'b111, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    tab.push_back(V(3'b111, 3'b000, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1));
    tab.push_back(V(3'b110, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b001, 1));
    tab.push_back(V(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    run_tab("rr");

    // Burst cap with contention: 4 plots from 0, then 1, then 0 again
    do_reset();
    tab.push_back(V(3'b011, 3'b000, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1));
    for (int k = 0; k < 3; k++) tab.push_back(V(3'b011, 3'b001, 60 + k, k, k, 0, 1, 3'b001, 3'b000, 1));
    tab.push_back(V(3'b011, 3'b001, 63, 3, 3, 0, 1, 3'b000, 3'b001, 1));
    tab.push_back(V(3'b011, 3'b001, 64, 4, 4, 0, 0, 3'b000, 3'b000, 0));
    tab.push_back(V(3'b011, 3'b001, 65, 5, 5, 0, 0, 3'b010, 3'b000, 1));
    tab.push_back(V(3'b011, 3'b010, 66, 6, 6, 1, 1, 3'b010, 3'b000, 1));
    tab.push_back(V(3'b001, 3'b010, 67, 7, 7, 1, 1, 3'b000, 3'b010, 1));
    tab.push_back(V(3'b001, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    tab.push_back(V(3'b001, 3'b000, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1));
    tab.push_back(V(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b001, 1));
    tab.push_back(V(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    run_tab("cap");

    // Cap without contention: 10 pixels, then a saturated counter preempts on new req
    do_reset();
    tab.push_back(V(3'b001, 3'b000, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1));
    for (int k = 0; k < 10; k++) tab.push_back(V(3'b001, 3'b001, 20 + k, k, k, 0, 1, 3'b001, 3'b000, 1));
    tab.push_back(V(3'b011, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b001, 1));
    tab.push_back(V(3'b010, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    tab.push_back(V(3'b010, 3'b000, 0, 0, 0, 0, 0, 3'b010, 3'b000, 1));
    tab.push_back(V(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b010, 1));
    tab.push_back(V(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    run_tab("nocont");

    // Strobes from non-granted requesters are ignored; vga_x holds 40
    do_reset();
    tab.push_back(V(3'b001, 3'b000, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1));
    tab.push_back(V(3'b001, 3'b001, 40, 9, 5, 0, 1, 3'b001, 3'b000, 1));
    tab.push_back(V(3'b001, 3'b110, 77, 20, 2, 0, 0, 3'b001, 3'b000, 1));
    tab.push_back(V(3'b000, 3'b110, 77, 20, 2, 0, 0, 3'b000, 3'b001, 1));
    tab.push_back(V(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0));
    run_tab("ignore");

    // Reset asserted while the 3rd pixel is being written
    do_reset();
    step(V(3'b001, 3'b000, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1), "mid0");
    step(V(3'b001, 3'b001, 50, 1, 1, 0, 1, 3'b001, 3'b000, 1), "mid1");
    step(V(3'b001, 3'b001, 51, 2, 2, 0, 1, 3'b001, 3'b000, 1), "mid2");
    @(negedge clk);
    drive(V(3'b001, 3'b001, 52, 3, 3, 0, 0, 3'b000, 3'b000, 0));
    #2 reset_n = 1'b0;
    #1;
    chk("midrst gnt", 32'(gnt), 0);
    chk("midrst plot", 32'(vga_plot), 0);
    chk("midrst done", 32'(done), 0);
    chk("midrst busy", 32'(busy), 0);
    chk("midrst vga_x", 32'(vga_x), 0);
    @(posedge clk);
    #1;
    chk("midrst edge plot", 32'(vga_plot), 0);
    chk("midrst edge done", 32'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    req = '0; wr = '0;
    sb.delete();
    lastp = '{x: 8'd0, y: 7'd0, c: 3'd0};
    // Pointer back at NUM_REQ-1, so requester 0 beats 2
    step(V(3'b101, 3'b000, 0, 0, 0, 0, 0, 3'b001, 3'b000, 1), "post0");
    step(V(3'b100, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b001, 1), "post1");
    step(V(3'b100, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b000, 0), "post2");
    step(V(3'b100, 3'b000, 0, 0, 0, 0, 0, 3'b100, 3'b000, 1), "post3");
    step(V(3'b000, 3'b000, 0, 0, 0, 0, 0, 3'b000, 3'b100, 1), "post4");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule

// File: doc/draw_port_arbiter.md
Name: draw_port_arbiter

Overview:
- Shares the single VGA-adapter pixel write port between NUM_REQ drawing engines: player crosshair clear/draw, duck sprite, and background/score.
- A requester holds the port for an atomic burst, e.g. a whole sprite erase or redraw.
- Grants rotate round-robin. An optional burst cap stops one engine from starving the others within a frame.
- The arbiter registers the winning pixel and drives the adapter's x/y/colour/plot inputs.

Parameters:
- NUM_REQ, 3, number of requesters (index 0..NUM_REQ-1).
- X_W, 8, pixel x width.
- Y_W, 7, pixel y width.
- COL_W, 3, colour width.
- MAX_BURST, 0, pixels allowed per grant before forced release; 0 means unlimited.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester port request; held high for the whole burst.
- wr  in  NUM_REQ  per-requester pixel write strobe; honoured only while that requester is granted.
- x_in  in  NUM_REQ*X_W  packed x; requester i occupies bits [i*X_W +: X_W].
- y_in  in  NUM_REQ*Y_W  packed y, same packing.
- col_in  in  NUM_REQ*COL_W  packed colour, same packing.
- gnt  out  NUM_REQ  one-hot grant; all zero when no requester owns the port.
- done  out  NUM_REQ  one-cycle pulse to requester i when its grant ends.
- vga_x  out  X_W  registered pixel x to the adapter.
- vga_y  out  Y_W  registered pixel y.
- vga_colour  out  COL_W  registered colour.
- vga_plot  out  1  registered write enable to the adapter.
- busy  out  1  high whenever state is not S_IDLE.

Behaviour:
- Reset (asynchronous, reset_n low):
  - state=S_IDLE; gnt=0; done=0; vga_plot=0; vga_x/vga_y/vga_colour=0; busy=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
  - Burst counter=0.
- State machine, 3 states:
  - S_IDLE:
    - If any req, pick the first set bit scanning last+1, last+2, … modulo NUM_REQ.
    - gnt[winner]<=1, last<=winner, counter<=0, go to S_GRANT.
    - Otherwise stay in S_IDLE.
    - Grant appears the cycle after req is first seen (1-cycle arbitration latency).
  - S_GRANT (owner g):
    - Each cycle with wr[g]=1: register x/y/col of g into vga_*, set vga_plot=1 next cycle, counter<=counter+1.
    - Cycles with wr[g]=0 produce vga_plot=0.
    - Exit to S_RELEASE (gnt<=0) when req[g]=0.
    - Also exit when MAX_BURST!=0, counter+wr[g] reaches MAX_BURST, and some other req bit is set (preemption).
    - If no other requester is waiting, the cap is ignored and the counter saturates at MAX_BURST.
  - S_RELEASE:
    - done[g]=1 for exactly this cycle; gnt=0; vga_plot=0 unless a final write was registered on the exit cycle.
    - Next state S_IDLE.
    - A preempted requester that still holds req re-enters arbitration normally at lowest round-robin priority.
- Write path:
  - wr from a non-granted requester is ignored.
  - The write issued on the same cycle req[g] drops is still plotted, so the final pixel is not lost.
  - Pixel latency is wr -> vga_plot exactly 1 cycle.
  - Plots are never reordered or duplicated.
- Simultaneous events:
  - Multiple new reqs in S_IDLE: round-robin decides.
  - req dropping on the cap cycle: treated as a normal release; done pulses once.
- Grant gaps:
  - At least 2 cycles with gnt=0 between consecutive grants (S_RELEASE, then S_IDLE).
  - Back-to-back winners see gnt low for those cycles.
- Reset mid-burst:
  - Everything clears immediately; the in-flight pixel is dropped; no done pulse is issued.
- Outputs:
  - gnt, done, vga_* and busy are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Single requester: after reset, req=001, wr high 4 cycles with x=10..13, y=5, col=3 -> gnt=001 one cycle after req; vga_plot high 4 cycles with vga_x 10..13, each one cycle after its wr; done[0] pulses one cycle after req drops.
- Round-robin: req=111 held, each burst 2 pixels then drop -> grant order 0,1,2,0; at least 2 gnt-low cycles between grants.
- Burst cap: MAX_BURST=4, req=011 held, requester 0 writes continuously -> exactly 4 plots from 0, then done[0], then gnt=010; requester 0 regranted after requester 1 releases.
- Cap with no contention: MAX_BURST=4, only req[0], 10 writes -> all 10 pixels plotted and no preemption.
- Ignored strobe: gnt=001, wr=110 with distinct coordinates -> vga_plot stays 0 and vga_x is unchanged.
- Mid-burst reset: pull reset_n low during the 3rd pixel -> gnt, vga_plot and done go 0 immediately; after release, req=100 is granted (pointer reset to NUM_REQ-1).
